// File: rtl/window_3x3_if.sv
// window_3x3_if
// Groups the raster pixel input and the 3x3 window output of window_3x3_gen.
//   pixel_in         [7:0]  incoming greyscale pixel, raster order
//   pixel_in_valid          pixel_in is consumed this cycle (no backpressure)
//   pixel_data       [71:0] 3x3 window, byte i = 3*row + col, byte 0 = oldest
//   pixel_data_valid        pixel_data holds a complete window this cycle
//   window_last             final window of the frame (qualified by valid)
// master: the side that supplies pixels and receives windows.
// slave:  the window generator.
interface window_3x3_if;
  logic [7:0]  pixel_in;
  logic        pixel_in_valid;
  logic [71:0] pixel_data;
  logic        pixel_data_valid;
  logic        window_last;

  modport master (
    output pixel_in, pixel_in_valid,
    input  pixel_data, pixel_data_valid, window_last
  );

  modport slave (
    input  pixel_in, pixel_in_valid,
    output pixel_data, pixel_data_valid, window_last
  );
endinterface

// File: rtl/window_3x3_gen.sv
// window_3x3_gen
// Raster-to-window stage ahead of the Gaussian blur convolver. Keeps the two
// previous image rows in line buffers and, for every accepted pixel that
// completes a full 3x3 neighbourhood (row >= 2, col >= 2), emits that
// neighbourhood as one 72-bit word one cycle after the accepting edge.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears control, window and outputs)
//   px     window_3x3_if.slave: pixel_in/pixel_in_valid in,
//          pixel_data/pixel_data_valid/window_last out
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic          clk,
  input  logic          rst_n,
  window_3x3_if.slave   px
);

  localparam int DATA_W = 8;
  localparam int WIN_W  = 9 * DATA_W;
  localparam int CW     = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [WIN_W-1:0]    pixel_data_q, pixel_data_d;
  logic                pixel_data_valid_q, pixel_data_valid_d;
  logic                window_last_q, window_last_d;

  // Line buffers hold pixel data only, so they carry no reset.
  logic [DATA_W-1:0]   lb1_mem [IMG_WIDTH];
  logic [DATA_W-1:0]   lb2_mem [IMG_WIDTH];

  logic [DATA_W-1:0]   top_px;
  logic [DATA_W-1:0]   mid_px;
  logic                col_end;
  logic                row_end;
  logic                qualify;

  always_comb begin
    col_d              = col_q;
    row_d              = row_q;
    win_d              = win_q;
    pixel_data_d       = pixel_data_q;
    pixel_data_valid_d = 1'b0;
    window_last_d      = 1'b0;

    // Pre-update buffer contents: rows r-2 and r-1 at the current column.
    top_px  = lb2_mem[col_q];
    mid_px  = lb1_mem[col_q];
    col_end = (col_q == COL_LAST);
    row_end = (row_q == ROW_LAST);
    qualify = (row_q >= ROW_TWO) && (col_q >= COL_TWO);

    if (px.pixel_in_valid) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      // Shift each window row one column left; the new column enters at colidx 2.
      for (int rr = 0; rr < 3; rr++) begin
        win_d[(3*rr)*DATA_W   +: DATA_W] = win_q[(3*rr+1)*DATA_W +: DATA_W];
        win_d[(3*rr+1)*DATA_W +: DATA_W] = win_q[(3*rr+2)*DATA_W +: DATA_W];
      end
      win_d[2*DATA_W +: DATA_W] = top_px;
      win_d[5*DATA_W +: DATA_W] = mid_px;
      win_d[8*DATA_W +: DATA_W] = px.pixel_in;

      // Only qualifying pixels update the output word, so it holds between pulses
      // and a window straddling a row or frame boundary is never published.
      pixel_data_valid_d = qualify;
      window_last_d      = qualify && row_end && col_end;
      if (qualify) begin
        pixel_data_d = win_d;
      end
    end
  end

  // Stage boundary: accepting edge -> registered window and output strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q              <= '0;
      row_q              <= '0;
      win_q              <= '0;
      pixel_data_q       <= '0;
      pixel_data_valid_q <= 1'b0;
      window_last_q      <= 1'b0;
    end else begin
      col_q              <= col_d;
      row_q              <= row_d;
      win_q              <= win_d;
      pixel_data_q       <= pixel_data_d;
      pixel_data_valid_q <= pixel_data_valid_d;
      window_last_q      <= window_last_d;
    end
  end

  // Read-before-write: lb2 takes the old lb1 value, lb1 takes the new pixel.
  always_ff @(posedge clk) begin
    if (px.pixel_in_valid) begin
      lb2_mem[col_q] <= lb1_mem[col_q];
      lb1_mem[col_q] <= px.pixel_in;
    end
  end

  assign px.pixel_data       = pixel_data_q;
  assign px.pixel_data_valid = pixel_data_valid_q;
  assign px.window_last      = window_last_q;

endmodule

// File: doc/window_3x3_gen.md
# window_3x3_gen

Raster-to-window stage that sits directly upstream of the Gaussian blur convolver. It accepts one 8-bit greyscale pixel per valid cycle in row-major order and stores the two previous image rows in line buffers. For every pixel position that completes a full 3x3 neighbourhood, it emits that neighbourhood as one 72-bit word with a valid strobe. The output format matches the convolver's `pixel_data` / `pixel_data_valid` input exactly.

## Interface
- `IMG_WIDTH`, default 640: pixels per row; minimum 3.
- `IMG_HEIGHT`, default 480: rows per frame; minimum 3.
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `pixel_in`  input  8  incoming pixel, raster order.
- `pixel_in_valid`  input  1  `pixel_in` is accepted this cycle. There is no backpressure; every valid cycle is consumed.
- `pixel_data`  output  72  3x3 window.
- `pixel_data_valid`  output  1  `pixel_data` holds a complete window this cycle.
- `window_last`  output  1  asserted together with `pixel_data_valid` for the final window of a frame.

## Operation
- **Position counters:** `col` counts 0..IMG_WIDTH-1 and `row` counts 0..IMG_HEIGHT-1, with widths `$clog2` of each parameter. They advance only on accepted pixels.
  - At the end of a row: `col` wraps to 0 and `row` increments.
  - After pixel (IMG_HEIGHT-1, IMG_WIDTH-1): both wrap to 0, and the next accepted pixel is (0,0) of a new frame.
- **Line buffers:** two arrays of IMG_WIDTH x 8 bits. `lb1` holds row r-1 and `lb2` holds row r-2. For an accepted pixel p at (r,c):
  - the column vector {top=`lb2[c]`, mid=`lb1[c]`, bottom=p} is shifted into the window register, using pre-update buffer values;
  - `lb2[c]` is written with the old `lb1[c]`;
  - `lb1[c]` is written with p.
  - Reads of `lb1[c]`/`lb2[c]` and the writes to them occur in the same cycle; the read returns the old value.
- **Window register:** 9 x 8 bits, organised as three rows of three.
  - On each accepted pixel the columns shift left (oldest column discarded) and the new column enters on the right.
  - Nothing changes on non-valid cycles.
- **Output packing:** byte i = 3*rowidx + colidx occupies `pixel_data[8i+7:8i]`.
  - rowidx 0 is the top (oldest) row; colidx 0 is the leftmost (oldest) column.
  - Byte 0 is therefore pixel (r-2,c-2) and byte 8 is pixel (r,c).
- **Qualification:** a window is valid when the accepted pixel has r>=2 and c>=2. This yields (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame.
  - No padding is applied at image borders.
  - Windows straddling a row boundary (c<2) are never flagged valid.
- **Stale data:** line buffers are not cleared at frame boundaries. Qualification alone guarantees no window mixes frames.

## Timing
- **Latency:** `pixel_data_valid` asserts exactly 1 cycle after the accepting edge of the pixel that completes the window.
  - `pixel_data` and `window_last` are registered and change on that same edge.
- `pixel_data_valid` is a single-cycle pulse per qualifying pixel. Back-to-back valid inputs give back-to-back valid outputs.
- `pixel_data` holds its last value while `pixel_data_valid`=0. Downstream must sample only on valid.
- **Bubbles:** any pattern of `pixel_in_valid` gaps is legal. The output sequence is identical to a gap-free stream; only the timing stretches.
- **Reset values:** `pixel_data`=0, `pixel_data_valid`=0, `window_last`=0, counters=0, window register=0. Line buffer contents are undefined and never read in a way that matters.
- **Reset mid-frame:** all outputs clear immediately (asynchronously). After `rst_n` releases, the first accepted pixel is (0,0).
- **Integration:** the downstream convolver adds 3 cycles, so pixel-in to blurred-out latency is 4 cycles.

## Test plan
- **Single frame, IMG_WIDTH=5, IMG_HEIGHT=4:** stream pixel values 16*r+c continuously. Expect:
  - exactly 6 valid pulses;
  - first pulse 1 cycle after pixel (2,2), with `pixel_data`=72'h222120121110020100;
  - last pulse `pixel_data`=72'h343332242322141312 with `window_last`=1;
  - no other `window_last`.
- **Bubbles:** same frame with `pixel_in_valid` randomly deasserted about 50% of cycles. Expect:
  - the same 6 windows in the same order;
  - each valid pulse 1 cycle after its accepting edge;
  - `pixel_data` stable between pulses.
- **Back-to-back frames:** second frame uses values 0x80+16*r+c. Expect:
  - no valid pulse during second-frame rows 0-1;
  - first second-frame window = 72'hA2A1A0929190828180.
- **Row edges:** per row r>=2, exactly IMG_WIDTH-2 pulses. No pulse for pixels at c=0 or c=1.
- **Reset mid-frame:** drop `rst_n` after 12 pixels, with no clock edge needed. Expect:
  - outputs 0 immediately;
  - after release, a fresh 5x4 frame yields exactly 6 windows matching scenario 1.
- **Integration with convolver:** all pixels 255. Expect `convolved_data`=255 on every `convolved_data_valid`, 4 cycles after the qualifying input pixel.
